fir_decimator: RTL
==================

FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, the sample width matching the FIR output.
REQ-002 The block SHALL have parameter FIR_DEPTH, default 128, the width of the tap overflow vectors.
REQ-003 The block SHALL have parameter DECIM, default 4, the keep-one-in-N decimation ratio, legal range 1..256.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, the output buffer entries, a power of 2 and at least 2.
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-006 Port i_clk, input, 1 bit: the clock, shared with the FIR filter.
REQ-007 Port i_rst, input, 1 bit: asynchronous active-low reset.
REQ-008 Port i_en, input, 1 bit: the sample strobe, the same signal that enables the FIR filter.
REQ-009 Port iv_din, input, DATA_WIDTH bits, signed: the FIR filter output sample.
REQ-010 Port iv_prod_overflow, input, FIR_DEPTH bits: per-tap product overflow.
REQ-011 Port iv_sum_overflow, input, FIR_DEPTH bits: per-tap sum overflow.
REQ-012 Port i_clr_flags, input, 1 bit: synchronous clear of all sticky flags.
REQ-013 Port i_ready, input, 1 bit: the downstream consumer accepts the head sample.
REQ-014 Port ov_dout, output, DATA_WIDTH bits, signed: the FIFO head sample.
REQ-015 Port o_valid, output, 1 bit: ov_dout holds a valid sample.
REQ-016 Port ov_level, output, $clog2(FIFO_DEPTH)+1 bits: the FIFO occupancy.
REQ-017 Port o_prod_ovf, output, 1 bit: sticky OR of all product-overflow bits.
REQ-018 Port o_sum_ovf, output, 1 bit: sticky OR of all sum-overflow bits.
REQ-019 Port o_drop, output, 1 bit: sticky flag set when a sample is lost to a full FIFO.

Function
REQ-020 The block SHALL register i_en into en_d; a cycle with en_d=1 is a sample cycle, and iv_din is sampled in that cycle, one cycle after the strobe.
REQ-021 The phase counter SHALL count 0..DECIM-1 and advance by one on each sample cycle, wrapping from DECIM-1 to 0.
REQ-022 A sample cycle with phase==0 SHALL push iv_din into the FIFO; with DECIM=1, every sample is pushed.
REQ-023 A pop SHALL occur when o_valid=1 and i_ready=1 at a clock edge, and the next entry SHALL appear on ov_dout in the following cycle.
REQ-024 o_valid SHALL equal (ov_level != 0), and ov_dout SHALL be the oldest entry; first-word latency from push to o_valid is 1 cycle.
REQ-025 A push while full and without a simultaneous pop SHALL be discarded, SHALL set o_drop, and SHALL leave FIFO contents and ov_level unchanged.
REQ-026 A push and a pop in the same cycle while full SHALL both succeed, with ov_level staying at FIFO_DEPTH.
REQ-027 A push and a pop in the same cycle at any other level SHALL leave ov_level unchanged.
REQ-028 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 On a sample cycle, o_prod_ovf SHALL set if any bit of iv_prod_overflow is 1, and o_sum_ovf SHALL set if any bit of iv_sum_overflow is 1, regardless of phase.
REQ-030 Overflow inputs SHALL be ignored outside sample cycles.
REQ-031 i_clr_flags SHALL clear o_prod_ovf, o_sum_ovf and o_drop on the next edge; a set event in the same cycle SHALL win over the clear.
REQ-032 Sample data SHALL pass through bit-exact, with no rounding or saturation.

Reset
REQ-033 i_rst=0 SHALL immediately force: en_d=0, phase=0, pointers=0, ov_level=0, o_valid=0, ov_dout=0, o_prod_ovf=0, o_sum_ovf=0, o_drop=0.
REQ-034 Reset asserted mid-stream SHALL discard all buffered samples, and the first sample cycle after release SHALL be phase 0 and SHALL be pushed.
REQ-035 Reset deassertion SHALL be synchronized to i_clk by the system reset generator, not inside the block.

Structure
REQ-036 The DATA_WIDTH and FIR_DEPTH defaults SHALL live in the shared FIR configuration package used by the filter; DECIM and FIFO_DEPTH SHALL be local parameters of this block.
REQ-037 The FIFO SHALL be a separate sub-module, sync_fifo (push/pop/full/empty/level), instantiated once; phase counting and sticky flags SHALL reside in fir_decimator.

Verification
REQ-038 DECIM=4, with i_en pulsing every 2 cycles, samples 1..12 and i_ready=1: ov_dout SHALL show 1, 5, 9, with o_drop=0.
REQ-039 FIFO_DEPTH=4 and i_ready=0, with 6 decimated samples 10..15: ov_level SHALL saturate at 4, o_drop SHALL be 1, and draining SHALL yield 10, 11, 12, 13.
REQ-040 FIFO full, with push and i_ready=1 in the same cycle: ov_level SHALL remain 4, o_drop SHALL stay 0, and order SHALL be preserved.
REQ-041 iv_sum_overflow bit 127 high on one sample cycle only: o_sum_ovf SHALL be 1 and stay 1; i_clr_flags SHALL clear it on the next edge; a simultaneous set and clear SHALL leave it at 1.
REQ-042 Reset pulse after 3 buffered samples and phase=2: all outputs SHALL be 0 immediately, and the first post-reset sample SHALL be output.
REQ-043 DECIM=1, with back-to-back i_en and samples -8388608, 8388607: ov_dout SHALL reproduce both values bit-exact.

Source files
------------

// File: rtl/fir_decimator_pkg.sv
// Shared FIR configuration: default sample/tap widths used by the filter and
// the decimator, plus the sticky status-flag record.
package fir_decimator_pkg;

   localparam int FIR_DATA_WIDTH = 24;
   localparam int FIR_TAP_COUNT  = 128;

   typedef struct packed {
      logic prod_ovf;
      logic sum_ovf;
      logic drop;
   } sticky_flags_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output. The head reads as zero while
// empty so the output is well defined straight out of reset. Storage is not
// reset; only pointers and occupancy are.
module sync_fifo
   import fir_decimator_pkg::*;
#(
   parameter int DATA_WIDTH = FIR_DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic signed [DATA_WIDTH-1:0] din,
   output logic signed [DATA_WIDTH-1:0] dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       level
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LEVEL_W = PTR_W + 1;

   logic signed [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]             wr_ptr;
   logic [PTR_W-1:0]             rd_ptr;
   logic                         wr_en;
   logic                         rd_en;

   assign full  = (level == LEVEL_W'(DEPTH));
   assign empty = (level == '0);

   // A push into a full FIFO only lands when the head leaves in the same edge.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   assign dout = empty ? '0 : mem[rd_ptr];

   // Sample storage; pointer width makes the wrap modulo DEPTH implicit.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // Read/write pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/fir_decimator.sv
// Keep-one-in-DECIM decimator behind the FIR filter. The FIR output is valid
// one cycle after its enable strobe, so the strobe is delayed once to mark the
// sample cycle. Kept samples go into an output FIFO; product/sum overflow and
// FIFO drops are accumulated into sticky flags.
module fir_decimator
   import fir_decimator_pkg::*;
#(
   parameter int DATA_WIDTH = FIR_DATA_WIDTH,
   parameter int FIR_DEPTH  = FIR_TAP_COUNT,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_en,
   input  logic signed [DATA_WIDTH-1:0] iv_din,
   input  logic [FIR_DEPTH-1:0]         iv_prod_overflow,
   input  logic [FIR_DEPTH-1:0]         iv_sum_overflow,
   input  logic                         i_clr_flags,
   input  logic                         i_ready,
   output logic signed [DATA_WIDTH-1:0] ov_dout,
   output logic                         o_valid,
   output logic [$clog2(FIFO_DEPTH):0]  ov_level,
   output logic                         o_prod_ovf,
   output logic                         o_sum_ovf,
   output logic                         o_drop
);

   localparam int                 PHASE_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

   logic               en_d;
   logic [PHASE_W-1:0] phase;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   sticky_flags_t      flags;
   sticky_flags_t      flags_set;

   assign push    = en_d && (phase == '0);
   assign pop     = o_valid && i_ready;
   assign o_valid = !empty;

   // Delay the strobe so the sample cycle lines up with the FIR output.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) en_d <= 1'b0;
      else        en_d <= i_en;
   end

   // Decimation phase: advances once per sample cycle, wraps at DECIM-1.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)    phase <= '0;
      else if (en_d) phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
   end

   // Set events for the sticky flags; overflow is only meaningful on sample cycles.
   always_comb begin
      flags_set          = '0;
      flags_set.prod_ovf = en_d && (|iv_prod_overflow);
      flags_set.sum_ovf  = en_d && (|iv_sum_overflow);
      flags_set.drop     = push && full && !pop;
   end

   // Sticky flags: a set event in the same cycle as a clear wins.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) flags <= '0;
      else        flags <= flags_set | (flags & {3{!i_clr_flags}});
   end

   assign o_prod_ovf = flags.prod_ovf;
   assign o_sum_ovf  = flags.sum_ovf;
   assign o_drop     = flags.drop;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst),
      .push  (push),
      .pop   (pop),
      .din   (iv_din),
      .dout  (ov_dout),
      .full  (full),
      .empty (empty),
      .level (ov_level)
   );

endmodule
